// File: rtl/sha256_block_feeder_pkg.sv
// Shared types and constants for the SHA-256 block feeder.
// Optional byte-granular tails are enabled by defining SHA256_FEEDER_BYTE_EN.
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [15:0] block_t;
  typedef word_t [7:0]  hash_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_PAD     = 3'd2,
    S_LEN     = 3'd3,
    S_START   = 3'd4,
    S_WAIT_LO = 3'd5,
    S_WAIT_HI = 3'd6,
    S_OUT     = 3'd7
  } feeder_state_t;

  // Element 0 is H0.
  localparam hash_t SHA256_IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                 32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam word_t PAD_WORD = 32'h80000000;

endpackage

// File: rtl/sha256_block_feeder_if.sv
// Handshake bus between the block feeder (master) and one simplified_sha256 core (slave).
interface sha256_block_feeder_if;
  import sha256_pkg::*;

  logic   core_start;
  logic   core_new_hashes;
  block_t core_message;
  hash_t  core_in;
  hash_t  core_sha;
  logic   core_done;

  modport master (
    output core_start, core_new_hashes, core_message, core_in,
    input  core_sha, core_done
  );

  modport slave (
    input  core_start, core_new_hashes, core_message, core_in,
    output core_sha, core_done
  );
endinterface

// File: rtl/sha256_block_feeder_tail_pack.sv
// Last-word packer: keeps the valid bytes, inserts the 0x80 marker after them.
// With SHA256_FEEDER_BYTE_EN undefined every tail is a full word and 0x80 always carries.
module sha256_tail_pack
  import sha256_pkg::*;
(
  input  word_t      data_word,
  input  logic [2:0] n_bytes,
  output word_t      tail_word,
  output logic       carry_pad,
  output logic [2:0] eff_bytes
);

`ifdef SHA256_FEEDER_BYTE_EN
  // Byte mask and marker insertion; out-of-range counts behave as a full word.
  always_comb begin
    tail_word = data_word;
    carry_pad = 1'b0;
    eff_bytes = n_bytes;
    case (n_bytes)
      3'd0: tail_word = PAD_WORD;
      3'd1: tail_word = {data_word[31:24], 8'h80, 16'h0000};
      3'd2: tail_word = {data_word[31:16], 8'h80, 8'h00};
      3'd3: tail_word = {data_word[31:8], 8'h80};
      default: begin
        tail_word = data_word;
        carry_pad = 1'b1;
        eff_bytes = 3'd4;
      end
    endcase
  end
`else
  logic unused_n_bytes_s;
  assign unused_n_bytes_s = ^n_bytes;

  // Whole-word messages only.
  always_comb begin
    tail_word = data_word;
    carry_pad = 1'b1;
    eff_bytes = 3'd4;
  end
`endif

endmodule

// File: rtl/sha256_block_feeder.sv
// SHA-256 front end: pads a 32-bit word stream, feeds 512-bit blocks to one core, chains H.
// Byte-granular tails require SHA256_FEEDER_BYTE_EN; otherwise in_bytes is ignored.
module sha256_block_feeder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  word_t                 in_data,
  input  logic                  in_last,
  input  logic [2:0]            in_bytes,
  sha256_block_feeder_if.master core,
  output hash_t                 digest,
  output logic                  digest_valid,
  input  logic                  digest_ready
);

  feeder_state_t    state_r, state_next_s;
  logic [3:0]       widx_r;
  logic [LEN_W-1:0] len_r;
  logic             first_r, final_r, pend_r, spill_r, ovf_r;
  block_t           msg_r;
  hash_t            h_r, digest_r;
  logic             in_ready_r, core_start_r, new_hashes_r, digest_valid_r;

  word_t            tail_word_s;
  logic             tail_carry_s;
  logic [2:0]       tail_bytes_s;
  logic             accept_s;
  word_t            pad_word_s;
  logic [63:0]      len64_s;

  sha256_tail_pack u_tail (
    .data_word (in_data),
    .n_bytes   (in_bytes),
    .tail_word (tail_word_s),
    .carry_pad (tail_carry_s),
    .eff_bytes (tail_bytes_s)
  );

  assign accept_s   = (state_r == S_FILL) && in_valid;
  assign pad_word_s = pend_r ? PAD_WORD : 32'h00000000;
  assign len64_s    = 64'(len_r);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= S_IDLE;
    else          state_r <= state_next_s;
  end

  // Next-state logic; spill means the 0x80 marker left no room for the length words.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: if (in_valid) state_next_s = S_FILL; else state_next_s = S_IDLE;
      S_FILL: begin
        if (!accept_s)                               state_next_s = S_FILL;
        else if (!in_last)                           state_next_s = (widx_r == 4'd15) ? S_START : S_FILL;
        else if (widx_r == 4'd15)                    state_next_s = S_START;
        else if ((widx_r == 4'd13) && !tail_carry_s) state_next_s = S_LEN;
        else                                         state_next_s = S_PAD;
      end
      S_PAD: begin
        if (widx_r == 4'd15)                     state_next_s = S_START;
        else if ((widx_r == 4'd13) && !spill_r)  state_next_s = S_LEN;
        else                                     state_next_s = S_PAD;
      end
      S_LEN:     state_next_s = S_START;
      S_START:   state_next_s = S_WAIT_LO;
      S_WAIT_LO: if (!core.core_done) state_next_s = S_WAIT_HI; else state_next_s = S_WAIT_LO;
      S_WAIT_HI: begin
        if (!core.core_done) state_next_s = S_WAIT_HI;
        else if (final_r)    state_next_s = S_OUT;
        else if (ovf_r)      state_next_s = S_PAD;
        else                 state_next_s = S_FILL;
      end
      S_OUT:   if (digest_ready) state_next_s = S_IDLE; else state_next_s = S_OUT;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Block assembly, length counting, hash chaining and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      widx_r         <= 4'd0;
      len_r          <= '0;
      first_r        <= 1'b1;
      final_r        <= 1'b0;
      pend_r         <= 1'b0;
      spill_r        <= 1'b0;
      ovf_r          <= 1'b0;
      msg_r          <= '0;
      h_r            <= '0;
      digest_r       <= '0;
      in_ready_r     <= 1'b0;
      core_start_r   <= 1'b0;
      new_hashes_r   <= 1'b0;
      digest_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          widx_r  <= 4'd0;
          len_r   <= '0;
          first_r <= 1'b1;
          final_r <= 1'b0;
          pend_r  <= 1'b0;
          spill_r <= 1'b0;
          ovf_r   <= 1'b0;
        end
        S_FILL: begin
          if (accept_s) begin
            widx_r <= widx_r + 4'd1;
            if (in_last) begin
              msg_r[widx_r] <= tail_word_s;
              len_r         <= len_r + LEN_W'({tail_bytes_s, 3'b000});
              pend_r        <= tail_carry_s;
              spill_r       <= (widx_r >= 4'd14) && !tail_carry_s;
              ovf_r         <= (widx_r == 4'd15);
            end else begin
              msg_r[widx_r] <= in_data;
              len_r         <= len_r + LEN_W'(6'd32);
            end
          end
        end
        S_PAD: begin
          msg_r[widx_r] <= pad_word_s;
          pend_r        <= 1'b0;
          widx_r        <= widx_r + 4'd1;
          if (pend_r && (widx_r >= 4'd14)) spill_r <= 1'b1;
          if (widx_r == 4'd15)             ovf_r   <= 1'b1;
        end
        S_LEN: begin
          msg_r[14] <= len64_s[63:32];
          msg_r[15] <= len64_s[31:0];
          final_r   <= 1'b1;
        end
        S_WAIT_HI: begin
          if (core.core_done) begin
            h_r     <= core.core_sha;
            first_r <= 1'b0;
            widx_r  <= 4'd0;
            spill_r <= 1'b0;
            ovf_r   <= 1'b0;
            if (final_r) digest_r <= core.core_sha;
          end
        end
        default: ;
      endcase
      in_ready_r     <= (state_next_s == S_FILL);
      core_start_r   <= (state_next_s == S_START);
      digest_valid_r <= (state_next_s == S_OUT);
      if (state_next_s == S_START) new_hashes_r <= ~first_r;
    end
  end

  assign in_ready             = in_ready_r;
  assign core.core_start      = core_start_r;
  assign core.core_new_hashes = new_hashes_r;
  assign core.core_message    = msg_r;
  assign core.core_in         = h_r;
  assign digest               = digest_r;
  assign digest_valid         = digest_valid_r;

endmodule
